// File: rtl/riscv_regfile_sb.sv
// Integer register file with write-to-read bypass and a per-register
// busy scoreboard, shared by decode (read/issue) and writeback.
module riscv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRS    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [NWR-1:0]      i_rd_wen,
    input  logic [NWR*5-1:0]    i_rd_addr,
    input  logic [NWR*XLEN-1:0] i_rd_data,
    input  logic [NRS*5-1:0]    i_rs_addr,
    output logic [NRS*XLEN-1:0] o_rs_data,
    output logic [NRS-1:0]      o_rs_busy,
    input  logic                i_sb_set,
    input  logic [4:0]          i_sb_addr,
    input  logic                i_sb_flush,
    output logic [NREG-1:0]     o_busy_vec
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;

    logic [NWR-1:0][4:0]       wa;
    logic [NWR-1:0][XLEN-1:0]  wd;
    logic [NWR-1:0]            wok;
    logic                      sok;
    logic [NRS-1:0]            hit;

    // x0 and addresses beyond the implemented file are never targets.
    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < NREG);
    endfunction

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa[k]  = i_rd_addr[5*k +: 5];
        assign wd[k]  = i_rd_data[XLEN*k +: XLEN];
        assign wok[k] = i_rd_wen[k] && in_range(i_rd_addr[5*k +: 5]);
    end

    assign sok = i_sb_set && in_range(i_sb_addr);

    // Later write ports override earlier ones; issue beats writeback clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wok[k]) begin
                regs_d[wa[k][AW-1:0]] = wd[k];
                busy_d[wa[k][AW-1:0]] = 1'b0;
            end
        end
        if (sok) begin
            busy_d[i_sb_addr[AW-1:0]] = 1'b1;
        end
        if (i_sb_flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        o_rs_data = '0;
        o_rs_busy = '0;
        hit       = '0;
        for (int r = 0; r < NRS; r++) begin
            if (in_range(i_rs_addr[5*r +: 5])) begin
                o_rs_data[XLEN*r +: XLEN] = regs_q[i_rs_addr[5*r +: AW]];
                o_rs_busy[r]              = busy_q[i_rs_addr[5*r +: AW]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wok[k] && (wa[k] == i_rs_addr[5*r +: 5])) begin
                            o_rs_data[XLEN*r +: XLEN] = wd[k];
                            hit[r]                    = 1'b1;
                        end
                    end
                    // A same-cycle issue to this register keeps stored busy.
                    if (hit[r] && !(i_sb_set &&
                                    (i_sb_addr == i_rs_addr[5*r +: 5]))) begin
                        o_rs_busy[r] = 1'b0;
                    end
                end
            end
        end
    end

    assign o_busy_vec = busy_q;

endmodule
